ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: the opposite direction of the keyboard receive path.
- Sends one command byte to the keyboard (0xED set LEDs, 0xF4 enable, 0xFF reset), e.g. to drive keyboard LEDs from the shift/ctrl/caps state.
- Drives ps2_clk/ps2_data as open-drain (output enable = pull low) and follows the device-generated clock.
- Reports completion, missing ack or timeout; asserts rx_inhibit so the receiver ignores frames while the host owns the bus.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles ps2_clk is held low before request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: max clk cycles from leaving INHIBIT to bus idle (15 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- tx_valid  in  1  command request.
- tx_data  in  8  command byte.
- tx_ready  out  1  high only in IDLE; transfer accepted when tx_valid && tx_ready.
- ps2_clk_i  in  1  sensed PS/2 clock line.
- ps2_data_i  in  1  sensed PS/2 data line.
- ps2_clk_oe  out  1  1 = pull clock low.
- ps2_data_oe  out  1  1 = pull data low.
- busy  out  1  high in any non-IDLE state.
- rx_inhibit  out  1  equals busy; receiver discards bits while high.
- done  out  1  one-cycle pulse: frame acked and bus idle.
- ack_error  out  1  one-cycle pulse: no ack at the 11th edge.
- timeout_error  out  1  one-cycle pulse: timeout expired.

Behaviour:
- Reset values: all outputs 0 except tx_ready=1; state IDLE; counters 0.
- ps2_clk_i/ps2_data_i pass through a 2-FF synchroniser.
  - fall = sync_clk_prev & ~sync_clk, one cycle wide.
  - fall is valid only after the 2-cycle sync latency.
- Parity: odd; par = ~^tx_data. Frame = {stop 1, par, data[7:0] LSB-first}, latched at accept.
- IDLE:
  - oe outputs 0.
  - On accept: latch frame, clear counters, go to INHIBIT.
- INHIBIT:
  - ps2_clk_oe=1, ps2_data_oe=0.
  - After INHIBIT_CYCLES cycles: ps2_data_oe=1 (start bit 0), ps2_clk_oe=0, start timeout counter, go to SEND.
- SEND:
  - Bit index k counts 0..9.
  - On each fall, present frame bit k: ps2_data_oe = ~bit, so a 1 releases the line.
  - Falls 1..8 present data, fall 9 presents parity, fall 10 presents stop (release).
  - After fall 10, go to ACK.
- ACK:
  - On the next fall (11th), sample sync_data.
  - 0: go to WAIT_IDLE.
  - 1: pulse ack_error, go to IDLE.
- WAIT_IDLE: when sync_clk && sync_data are both 1, pulse done and go to IDLE.
- Timeout:
  - Counter runs in SEND, ACK and WAIT_IDLE.
  - On reaching TIMEOUT_CYCLES: release both lines, pulse timeout_error, go to IDLE. Timeout has priority over a same-cycle fall.
- Any error or done returns to IDLE with both oe=0 in the same cycle as the pulse; tx_ready=1 on the next cycle.
- tx_valid while busy: ignored, not queued.
- rst mid-frame: oe outputs 0 in the cycle after rst sampled; no pulses issued.
- A fall seen in INHIBIT (device still clocking) is ignored; the host's clock hold aborts the device.

Optional Feature:
- Macro PS2_HOST_TX_RETRY_EN.
- Defined:
  - On ack_error or timeout, re-enter INHIBIT once with the same latched frame; error pulses are suppressed on the first failure.
  - The second failure pulses the error and goes to IDLE.
  - Extra output retried (1 bit), pulsed on retry start.
- Undefined: the first failure is final; the retried port is absent.

Decomposition:
- Shared package ps2_pkg:
  - State encodings: IDLE, INHIBIT, SEND, ACK, WAIT_IDLE.
  - Command constants: PS2_CMD_SET_LED=8'hED, PS2_CMD_ENABLE=8'hF4, PS2_CMD_RESET=8'hFF, PS2_ACK=8'hFA.
  - Odd-parity function.
- Sub-module ps2_line_sync: 2-FF synchroniser for clk/data plus falling-edge pulse. Reused by the receiver.

Test Plan (INHIBIT_CYCLES=8, TIMEOUT_CYCLES=400, device BFM clocks at period 20 after seeing data low with clk released):
- tx_data=0xED:
  - ps2_clk_oe high exactly 8 cycles.
  - Device samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - BFM acks; done pulses once; tx_ready returns to 1.
- tx_data=0xF4: parity bit 0; done pulses.
- tx_data=0xFF, BFM leaves data high at the 11th clock: ack_error pulse, both oe 0, no done.
- BFM never clocks after RTS: timeout_error after 400 cycles; ps2_data_oe drops the same cycle; state IDLE.
- tx_valid with 0x00 asserted mid-frame of 0xED: ignored; only 0xED is observed; tx_ready stays 0 until done.
- rst asserted after 4th bit: both oe 0 next cycle, busy 0, no pulses; a new 0xF4 then completes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, command bytes and
// the frame parity helper.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INHIBIT   = 3'd1,
      SEND      = 3'd2,
      ACK       = 3'd3,
      WAIT_IDLE = 3'd4
   } ps2_tx_state_e;

   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
   localparam logic [7:0] PS2_ACK         = 8'hFA;

   // PS/2 frames carry odd parity over the eight data bits.
   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the PS/2 clock and data lines plus a one-cycle
// falling-edge strobe on the synchronised clock. Shared with the receive path.
module ps2_line_sync
   import ps2_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk_i,
   input  logic ps2_data_i,
   output logic sync_clk_o,
   output logic sync_data_o,
   output logic fall_o
);

   logic [1:0] meta_q;
   logic [1:0] sync_q;
   logic       clk_prev_q;

   // Flops reset to the idle (released) level so no false edge follows reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q     <= 2'b11;
         sync_q     <= 2'b11;
         clk_prev_q <= 1'b1;
      end else begin
         meta_q     <= {ps2_data_i, ps2_clk_i};
         sync_q     <= meta_q;
         clk_prev_q <= sync_q[0];
      end
   end

   assign sync_clk_o  = sync_q[0];
   assign sync_data_o = sync_q[1];
   assign fall_o      = clk_prev_q & ~sync_q[0];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain line enables.
// Optional macro PS2_HOST_TX_RETRY_EN: one automatic retry and a 'retried' pulse.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       rx_inhibit,
   output logic       done,
   output logic       ack_error,
`ifdef PS2_HOST_TX_RETRY_EN
   output logic       retried,
`endif
   output logic       timeout_error
);

   localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic sync_clk;
   logic sync_data;
   logic fall;

   ps2_line_sync u_sync (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk_i   (ps2_clk_i),
      .ps2_data_i  (ps2_data_i),
      .sync_clk_o  (sync_clk),
      .sync_data_o (sync_data),
      .fall_o      (fall)
   );

   ps2_tx_state_e    state_q, state_d;
   logic [9:0]       frame_q, frame_d;
   logic [3:0]       bit_q, bit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clk_oe_q, clk_oe_d;
   logic             data_oe_q, data_oe_d;
   logic             done_q, done_d;
   logic             ack_err_q, ack_err_d;
   logic             to_err_q, to_err_d;
   logic             fail;
   logic             fail_timeout;
   logic             give_up;
`ifdef PS2_HOST_TX_RETRY_EN
   logic             retry_used_q, retry_used_d;
   logic             retried_q, retried_d;

   assign give_up = retry_used_q;
`else
   assign give_up = 1'b1;
`endif

   always_comb begin
      state_d      = state_q;
      frame_d      = frame_q;
      bit_d        = bit_q;
      cnt_d        = cnt_q;
      clk_oe_d     = clk_oe_q;
      data_oe_d    = data_oe_q;
      done_d       = 1'b0;
      ack_err_d    = 1'b0;
      to_err_d     = 1'b0;
      fail         = 1'b0;
      fail_timeout = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_used_d = retry_used_q;
      retried_d    = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (tx_valid) begin
               frame_d  = {1'b1, odd_parity(tx_data), tx_data};
               cnt_d    = '0;
               bit_d    = 4'd0;
               clk_oe_d = 1'b1;
               state_d  = INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
               retry_used_d = 1'b0;
`endif
            end
         end

         // Device falls here are ignored: holding the clock aborts the device.
         INHIBIT: begin
            if (cnt_q == INHIBIT_LAST) begin
               cnt_d     = '0;
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b1;
               state_d   = SEND;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         SEND, ACK, WAIT_IDLE: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == TIMEOUT_LAST) begin
               fail         = 1'b1;
               fail_timeout = 1'b1;
            end else if (state_q == SEND) begin
               if (fall) begin
                  data_oe_d = ~frame_q[bit_q];
                  bit_d     = bit_q + 4'd1;
                  if (bit_q == 4'd9) begin
                     state_d = ACK;
                  end
               end
            end else if (state_q == ACK) begin
               if (fall) begin
                  if (!sync_data) begin
                     state_d = WAIT_IDLE;
                  end else begin
                     fail = 1'b1;
                  end
               end
            end else if (sync_clk && sync_data) begin
               done_d    = 1'b1;
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
               state_d   = IDLE;
            end
         end

         default: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = IDLE;
         end
      endcase

      if (fail) begin
         if (give_up) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            ack_err_d = ~fail_timeout;
            to_err_d  = fail_timeout;
            state_d   = IDLE;
         end else begin
            // Second attempt replays the latched frame from a fresh inhibit.
            clk_oe_d  = 1'b1;
            data_oe_d = 1'b0;
            cnt_d     = '0;
            bit_d     = 4'd0;
            state_d   = INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_used_d = 1'b1;
            retried_d    = 1'b1;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         frame_q   <= '0;
         bit_q     <= 4'd0;
         cnt_q     <= '0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
         to_err_q  <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
         retry_used_q <= 1'b0;
         retried_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         bit_q     <= bit_d;
         cnt_q     <= cnt_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         done_q    <= done_d;
         ack_err_q <= ack_err_d;
         to_err_q  <= to_err_d;
`ifdef PS2_HOST_TX_RETRY_EN
         retry_used_q <= retry_used_d;
         retried_q    <= retried_d;
`endif
      end
   end

   assign tx_ready      = (state_q == IDLE);
   assign busy          = (state_q != IDLE);
   assign rx_inhibit    = busy;
   assign ps2_clk_oe    = clk_oe_q;
   assign ps2_data_oe   = data_oe_q;
   assign done          = done_q;
   assign ack_error     = ack_err_q;
   assign timeout_error = to_err_q;
`ifdef PS2_HOST_TX_RETRY_EN
   assign retried       = retried_q;
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple open-drain PS/2 device model.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH = 8;
   localparam int TO  = 400;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, rx_inhibit;
   logic       done, ack_error, timeout_error;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       clk_line, data_line;
`ifdef PS2_HOST_TX_RETRY_EN
   logic       retried;
`endif

   assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
   assign data_line = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clk           (clk),
      .rst           (rst),
      .tx_valid      (tx_valid),
      .tx_data       (tx_data),
      .tx_ready      (tx_ready),
      .ps2_clk_i     (clk_line),
      .ps2_data_i    (data_line),
      .ps2_clk_oe    (ps2_clk_oe),
      .ps2_data_oe   (ps2_data_oe),
      .busy          (busy),
      .rx_inhibit    (rx_inhibit),
      .done          (done),
      .ack_error     (ack_error),
`ifdef PS2_HOST_TX_RETRY_EN
      .retried       (retried),
`endif
      .timeout_error (timeout_error)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int done_seen = 0, ackerr_seen = 0, to_seen = 0, inh_cycles = 0;
   logic [1:0] oe_at_ackerr = 2'b11;
   logic [1:0] oe_at_to = 2'b11;

   always @(negedge clk) begin
      if (!rst) begin
         if (done) done_seen++;
         if (ack_error) begin
            ackerr_seen++;
            oe_at_ackerr = {ps2_clk_oe, ps2_data_oe};
         end
         if (timeout_error) begin
            to_seen++;
            oe_at_to = {ps2_clk_oe, ps2_data_oe};
         end
         if (ps2_clk_oe) inh_cycles++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic request(input logic [7:0] d);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (tx_ready) ok = 1'b1;
         else cyc(1);
      end
      check("req_ready", ok, 1);
      tx_valid = 1'b1;
      tx_data  = d;
      cyc(1);
      tx_valid = 1'b0;
   endtask

   // Device model: waits for request-to-send, generates nfall clocks of period 20
   // cycles sampling data while clock is low, then optionally acks on clock 11.
   task automatic bfm(input int nfall, input bit do_ack, output logic [10:0] fr, output bit found);
      found = 1'b0;
      fr = '1;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (!data_line && clk_line) found = 1'b1;
      end
      if (found) begin
         fr[0] = data_line;
         repeat (3) @(negedge clk);
         for (int k = 1; k <= nfall; k++) begin
            dev_clk_low = 1'b1;
            repeat (10) @(negedge clk);
            fr[k] = data_line;
            dev_clk_low = 1'b0;
            repeat (10) @(negedge clk);
         end
         if (nfall == 10) begin
            if (do_ack) dev_data_low = 1'b1;
            repeat (3) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (10) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (3) @(negedge clk);
            dev_data_low = 1'b0;
         end
      end
   endtask

   task automatic wait_idle(input string tag);
      bit ok;
      ok = 1'b0;
      cyc(1);
      for (int i = 0; i < 200 && !ok; i++) begin
         if (!busy) ok = 1'b1;
         else cyc(1);
      end
      check(tag, ok, 1);
      cyc(2);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0] fr;
      bit found, rdy_seen, to_hit;
      int d0, a0, t0, i0, n;

      cyc(3);
      rst = 1'b0;
      cyc(1);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_rx_inhibit", rx_inhibit, 0);
      check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      check("rst_pulses", {done, ack_error, timeout_error}, 0);

      // 0xED: start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1 -> 11'h7DA
      d0 = done_seen; a0 = ackerr_seen; i0 = inh_cycles;
      request(PS2_CMD_SET_LED);
      bfm(10, 1'b1, fr, found);
      check("ed_rts", found, 1);
      check("ed_frame", fr, 11'h7DA);
      wait_idle("ed_idle");
      check("ed_inhibit_len", inh_cycles - i0, INH);
      check("ed_done", done_seen - d0, 1);
      check("ed_no_ackerr", ackerr_seen - a0, 0);
      check("ed_tx_ready", tx_ready, 1);
      $display("tx 0xED frame=%03h done=%0d", fr, done_seen - d0);

      // 0xF4: parity bit 0 -> 11'h5E8
      d0 = done_seen;
      request(PS2_CMD_ENABLE);
      bfm(10, 1'b1, fr, found);
      check("f4_frame", fr, 11'h5E8);
      wait_idle("f4_idle");
      check("f4_done", done_seen - d0, 1);
      $display("tx 0xF4 frame=%03h done=%0d", fr, done_seen - d0);

      // 0xFF with no ack -> ack_error, frame 11'h7FE
      d0 = done_seen; a0 = ackerr_seen;
      request(PS2_CMD_RESET);
      bfm(10, 1'b0, fr, found);
      check("ff_frame", fr, 11'h7FE);
      wait_idle("ff_idle");
      check("ff_ackerr", ackerr_seen - a0, 1);
      check("ff_no_done", done_seen - d0, 0);
      check("ff_oe_at_err", oe_at_ackerr, 0);
      $display("tx 0xFF frame=%03h ack_error=%0d", fr, ackerr_seen - a0);

      // Device never clocks: timeout 400 cycles after leaving inhibit
      t0 = to_seen; d0 = done_seen;
      request(PS2_CMD_SET_LED);
      n = 0; to_hit = 1'b0;
      for (int i = 0; i < 1500 && !to_hit; i++) begin
         @(negedge clk);
         if (timeout_error) to_hit = 1'b1;
         else if (ps2_data_oe) n++;
      end
      check("to_hit", to_hit, 1);
      check("to_len", n, TO);
      wait_idle("to_idle");
      check("to_pulse", to_seen - t0, 1);
      check("to_oe_at_err", oe_at_to, 0);
      check("to_no_done", done_seen - d0, 0);
      check("to_tx_ready", tx_ready, 1);
      $display("tx 0xED timeout after %0d cycles", n);

      // Request while busy is ignored
      d0 = done_seen;
      rdy_seen = 1'b0;
      request(PS2_CMD_SET_LED);
      fork
         bfm(10, 1'b1, fr, found);
         begin
            cyc(60);
            tx_valid = 1'b1;
            tx_data  = 8'h00;
            repeat (20) begin
               @(negedge clk);
               if (tx_ready) rdy_seen = 1'b1;
            end
            tx_valid = 1'b0;
         end
      join
      check("busy_req_frame", fr, 11'h7DA);
      check("busy_req_ready", rdy_seen, 0);
      wait_idle("busy_req_idle");
      check("busy_req_done", done_seen - d0, 1);
      cyc(30);
      check("busy_req_not_queued", busy, 0);
      $display("tx 0xED with 0x00 mid-frame frame=%03h done=%0d", fr, done_seen - d0);

      // Reset after the 4th bit
      d0 = done_seen; a0 = ackerr_seen; t0 = to_seen;
      request(PS2_CMD_SET_LED);
      bfm(4, 1'b0, fr, found);
      check("rst_mid_rts", found, 1);
      cyc(1);
      rst = 1'b1;
      cyc(1);
      check("rst_mid_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      check("rst_mid_busy", busy, 0);
      rst = 1'b0;
      cyc(20);
      check("rst_mid_pulses", (done_seen - d0) + (ackerr_seen - a0) + (to_seen - t0), 0);
      $display("tx 0xED reset after 4 bits busy=%0d", busy);

      d0 = done_seen;
      request(PS2_CMD_ENABLE);
      bfm(10, 1'b1, fr, found);
      check("post_rst_frame", fr, 11'h5E8);
      wait_idle("post_rst_idle");
      check("post_rst_done", done_seen - d0, 1);
      $display("tx 0xF4 after reset frame=%03h done=%0d", fr, done_seen - d0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
